// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared segment constants for the 7-segment scan driver: active-high hex table and dark pattern.
// Pure constants and one combinational helper, so there is no latency and no backpressure.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit 0 is segment a and bit 6 is segment g; 1 means the segment is lit.
  localparam logic [6:0] HEX2SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_n_of(input logic [3:0] nibble);
    return ~HEX2SEG[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Control and pin bundle between the status logic and the display driver; blink_mask exists only under SEVEN_SEG_BLINK_EN.
// Wires only, so there is no latency; the display side never pushes back, so there is no backpressure.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     blank_mask;
`ifdef SEVEN_SEG_BLINK_EN
  logic [NUM_DIGITS-1:0]     blink_mask;
`endif
  logic [6:0]                seg_n;
  logic [NUM_DIGITS-1:0]     an_n;
  logic                      frame_tick;

`ifdef SEVEN_SEG_BLINK_EN
  modport master (output enable, load, digits_in, blank_mask, blink_mask,
                  input  seg_n, an_n, frame_tick);
  modport slave  (input  enable, load, digits_in, blank_mask, blink_mask,
                  output seg_n, an_n, frame_tick);
`else
  modport master (output enable, load, digits_in, blank_mask,
                  input  seg_n, an_n, frame_tick);
  modport slave  (input  enable, load, digits_in, blank_mask,
                  output seg_n, an_n, frame_tick);
`endif
endinterface

// File: rtl/seven_seg_scan_driver_hex.sv
// Hex nibble to active-low segment decoder.
// Purely combinational, so there is no latency and no backpressure.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = seg_n_of(nib_i);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode display scanner with blanking gaps and frame-aligned digit updates; SEVEN_SEG_BLINK_EN adds blink.
// Outputs are registered one cycle behind the scan state; there is no backpressure, and load is always accepted.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
`ifdef SEVEN_SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input logic                    clk,
  input logic                    rst_n,
  seven_seg_scan_driver_if.slave bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic                    frame_tick_q;
  logic                    slot_end, frame_end, dark;
  logic [3:0]              nibble;
  logic [6:0]              digit_seg_n;

  assign slot_end  = bus.enable && (div_cnt_q == DIV_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    if (bus.enable) begin
      div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
      if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A load landing on the boundary cycle must win over the older pending value.
  always_comb begin
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    shadow_d   = shadow_q;
    if (bus.load) begin
      pending_d  = bus.digits_in;
      pend_vld_d = 1'b1;
    end
    if (frame_end) begin
      if (bus.load)       shadow_d = bus.digits_in;
      else if (pend_vld_q) shadow_d = pending_q;
      pend_vld_d = 1'b0;
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  assign dark = bus.blank_mask[idx_q] | (blink_phase_q & bus.blink_mask[idx_q]);
`else
  assign dark = bus.blank_mask[idx_q];
`endif

  assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nib_i   (nibble),
    .seg_n_o (digit_seg_n)
  );

  always_comb begin
    an_n_d  = '1;
    seg_n_d = SEG_OFF;
    if (bus.enable && (div_cnt_q >= BLANK_END)) begin
      an_n_d[idx_q] = 1'b0;
      seg_n_d       = dark ? SEG_OFF : digit_seg_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      pending_q     <= '0;
      shadow_q      <= '0;
      pend_vld_q    <= 1'b0;
      seg_n_q       <= SEG_OFF;
      an_n_q        <= '1;
      frame_tick_q  <= 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      pend_vld_q    <= pend_vld_d;
      seg_n_q       <= seg_n_d;
      an_n_q        <= an_n_d;
      frame_tick_q  <= frame_end;
`ifdef SEVEN_SEG_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

  assign bus.seg_n      = seg_n_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// cyc counts scan-advancing edges since reset release; the output sampled after edge cyc shows scan state cyc-1.
module tb_seven_seg_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  seven_seg_scan_driver_if #(.NUM_DIGITS(4)) bus();

  seven_seg_scan_driver #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
`ifdef SEVEN_SEG_BLINK_EN
    ,
    .BLINK_FRAMES (2)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [6:0] tb_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int s);
    logic [3:0] r;
    r = 4'hF;
    if ((s % 8) >= 2) r[(s / 8) % 4] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int s, input logic [15:0] sh);
    logic [15:0] v;
    v = sh;
    if ((s % 8) < 2) return 7'h7F;
    return tb_seg(v[4*((s / 8) % 4) +: 4]);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic advance_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.load = 1'b0; bus.digits_in = '0; bus.blank_mask = '0;
`ifdef SEVEN_SEG_BLINK_EN
    bus.blink_mask = '0;
`endif
    rst_n = 1'b0;
    #12;
    checks++; if (bus.seg_n !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", bus.seg_n); end
    checks++; if (bus.an_n !== 4'hF) begin failures++; $display("FAIL reset_an got=%h exp=f", bus.an_n); end
    checks++; if (bus.frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus.frame_tick); end
    @(negedge clk); rst_n = 1'b1; cyc = 0;
    advance_to(2);
    checks++; if (bus.an_n !== 4'hF) begin failures++; $display("FAIL release_blank an_n got=%h exp=f", bus.an_n); end
    advance_to(3);
    checks++; if (bus.an_n !== 4'hE || bus.seg_n !== 7'h40) begin failures++; $display("FAIL release_first an_n=%h seg_n=%h exp e/40", bus.an_n, bus.seg_n); end
    advance_to(5);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.an_n !== 4'hF || bus.seg_n !== 7'h7F) begin failures++; $display("FAIL async_reset an_n=%h seg_n=%h exp f/7f", bus.an_n, bus.seg_n); end
    @(negedge clk); rst_n = 1'b1; cyc = 0;
    advance_to(2);
    checks++; if (bus.an_n !== 4'hF) begin failures++; $display("FAIL rerelease_blank an_n got=%h exp=f", bus.an_n); end
    advance_to(3);
    checks++; if (bus.an_n !== 4'hE || bus.seg_n !== 7'h40) begin failures++; $display("FAIL rerelease_first an_n=%h seg_n=%h exp e/40", bus.an_n, bus.seg_n); end
  endtask

  task automatic test_load_frame();
    logic [15:0] sh;
    int lit [4];
    for (int k = 0; k < 4; k++) lit[k] = 0;
    bus.load = 1'b1; bus.digits_in = 16'h1A3F;
    tick();
    bus.load = 1'b0; bus.digits_in = 16'h0000;
    while (cyc < 64) begin
      tick();
      sh = ((cyc - 1) >= 32) ? 16'h1A3F : 16'h0000;
      checks++;
      if (bus.an_n !== exp_an(cyc - 1) || bus.seg_n !== exp_seg(cyc - 1, sh)) begin
        failures++;
        $display("FAIL frame_scan cyc=%0d an_n=%h seg_n=%h exp %h/%h", cyc, bus.an_n, bus.seg_n, exp_an(cyc - 1), exp_seg(cyc - 1, sh));
      end
      checks++;
      if (bus.frame_tick !== (cyc == 32 || cyc == 64)) begin
        failures++; $display("FAIL frame_tick cyc=%0d got=%b", cyc, bus.frame_tick);
      end
      checks++;
      if ($countones(~bus.an_n) > 1) begin failures++; $display("FAIL an_onehot cyc=%0d an_n=%h", cyc, bus.an_n); end
      if (cyc > 32) for (int k = 0; k < 4; k++) if (bus.an_n[k] === 1'b0) lit[k]++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (lit[k] != 6) begin failures++; $display("FAIL lit_count digit=%0d got=%0d exp=6", k, lit[k]); end
    end
  endtask

  task automatic test_midframe_load();
    advance_to(75);
    bus.load = 1'b1; bus.digits_in = 16'h0000;
    tick();
    bus.load = 1'b0; bus.digits_in = 16'hFFFF;
    advance_to(86);
    checks++; if (bus.an_n !== 4'hB || bus.seg_n !== 7'h08) begin failures++; $display("FAIL mid_old_d2 an_n=%h seg_n=%h exp b/08", bus.an_n, bus.seg_n); end
    advance_to(94);
    checks++; if (bus.an_n !== 4'h7 || bus.seg_n !== 7'h79) begin failures++; $display("FAIL mid_old_d3 an_n=%h seg_n=%h exp 7/79", bus.an_n, bus.seg_n); end
    advance_to(96);
    checks++; if (bus.frame_tick !== 1'b1) begin failures++; $display("FAIL mid_tick got=%b exp=1", bus.frame_tick); end
    advance_to(99);
    checks++; if (bus.an_n !== 4'hE || bus.seg_n !== 7'h40) begin failures++; $display("FAIL mid_new_d0 an_n=%h seg_n=%h exp e/40", bus.an_n, bus.seg_n); end
  endtask

  task automatic test_back_to_back();
    advance_to(127);
    bus.load = 1'b1; bus.digits_in = 16'h8888;
    tick();
    bus.load = 1'b0; bus.digits_in = 16'h5555;
    checks++; if (bus.frame_tick !== 1'b1) begin failures++; $display("FAIL bnd_tick got=%b exp=1", bus.frame_tick); end
    advance_to(131);
    checks++; if (bus.an_n !== 4'hE || bus.seg_n !== 7'h00) begin failures++; $display("FAIL bnd_d0 an_n=%h seg_n=%h exp e/00", bus.an_n, bus.seg_n); end
    advance_to(139);
    checks++; if (bus.an_n !== 4'hD || bus.seg_n !== 7'h00) begin failures++; $display("FAIL bnd_d1 an_n=%h seg_n=%h exp d/00", bus.an_n, bus.seg_n); end
  endtask

  task automatic test_blank_enable();
    bus.blank_mask = 4'b0100;
    advance_to(148);
    checks++; if (bus.an_n !== 4'hB || bus.seg_n !== 7'h7F) begin failures++; $display("FAIL blank_d2 an_n=%h seg_n=%h exp b/7f", bus.an_n, bus.seg_n); end
    bus.enable = 1'b0; bus.load = 1'b1; bus.digits_in = 16'h2222;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      bus.load = 1'b0;
      checks++;
      if (bus.an_n !== 4'hF || bus.seg_n !== 7'h7F || bus.frame_tick !== 1'b0) begin
        failures++; $display("FAIL disabled_dark i=%0d an_n=%h seg_n=%h tick=%b", i, bus.an_n, bus.seg_n, bus.frame_tick);
      end
    end
    bus.blank_mask = 4'b0000; bus.enable = 1'b1;
    tick();
    checks++; if (bus.an_n !== 4'hB || bus.seg_n !== 7'h00) begin failures++; $display("FAIL resume_d2 an_n=%h seg_n=%h exp b/00", bus.an_n, bus.seg_n); end
    advance_to(153);
    checks++; if (bus.an_n !== 4'hF) begin failures++; $display("FAIL resume_gap an_n=%h exp f", bus.an_n); end
    advance_to(155);
    checks++; if (bus.an_n !== 4'h7 || bus.seg_n !== 7'h00) begin failures++; $display("FAIL resume_d3 an_n=%h seg_n=%h exp 7/00", bus.an_n, bus.seg_n); end
    advance_to(160);
    checks++; if (bus.frame_tick !== 1'b1) begin failures++; $display("FAIL resume_tick got=%b exp=1", bus.frame_tick); end
    advance_to(163);
    checks++; if (bus.an_n !== 4'hE || bus.seg_n !== 7'h24) begin failures++; $display("FAIL disabled_load an_n=%h seg_n=%h exp e/24", bus.an_n, bus.seg_n); end
  endtask

`ifdef SEVEN_SEG_BLINK_EN
  task automatic test_blink();
    logic [6:0] e;
    rst_n = 1'b0;
    bus.blink_mask = 4'b0001;
    #3;
    @(negedge clk); rst_n = 1'b1; cyc = 0;
    for (int f = 0; f < 6; f++) begin
      e = (((f / 2) % 2) == 1) ? 7'h7F : 7'h40;
      advance_to(32 * f + 3);
      checks++; if (bus.an_n !== 4'hE || bus.seg_n !== e) begin failures++; $display("FAIL blink_d0 frame=%0d an_n=%h seg_n=%h exp e/%h", f, bus.an_n, bus.seg_n, e); end
      advance_to(32 * f + 11);
      checks++; if (bus.an_n !== 4'hD || bus.seg_n !== 7'h40) begin failures++; $display("FAIL blink_d1 frame=%0d an_n=%h seg_n=%h exp d/40", f, bus.an_n, bus.seg_n); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_frame();
    test_midframe_load();
    test_back_to_back();
    test_blank_enable();
`ifdef SEVEN_SEG_BLINK_EN
    test_blink();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
